// File: rtl/menu_pkg.sv
// Shared definitions for the level-select menu controller.
// Contents: PS/2 scancodes of the keys the menu reacts to, the menu state
// encoding and the default number of menu rows.
package menu_pkg;

    localparam logic [8:0] KEY_UP    = 9'h075;
    localparam logic [8:0] KEY_DOWN  = 9'h072;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;

    localparam int unsigned MENU_ITEMS = 5;

    typedef enum logic [1:0] {
        IDLE,
        BROWSE,
        CONFIRM,
        LOCKED
    } menu_state_e;

endpackage

// File: rtl/menu_ctrl_key_step_gen.sv
// key_step_gen: turns PS/2 press events for UP/DOWN into one-cycle step pulses.
// Optional held-key auto-repeat is compiled in with MENU_CTRL_AUTOREPEAT_EN.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   active       repeat counter may run (menu is in BROWSE)
//   key_valid    last_change strobe
//   last_change  scancode of the latest make/break event
//   key_down     per-scancode held flags
//   step_up      one-cycle pulse: move highlight up
//   step_down    one-cycle pulse: move highlight down
module key_step_gen
    import menu_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 12_500_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         active,
    input  logic         key_valid,
    input  logic [8:0]   last_change,
    input  logic [511:0] key_down,
    output logic         step_up,
    output logic         step_down
);

    logic press;
    logic press_up;
    logic press_down;

    // Break events carry key_down[last_change] == 0 and are dropped here.
    assign press      = key_valid & key_down[last_change];
    assign press_up   = press & (last_change == KEY_UP);
    assign press_down = press & (last_change == KEY_DOWN);

`ifdef MENU_CTRL_AUTOREPEAT_EN
    logic [31:0] cnt_q;
    logic        first_q;   // still waiting out the initial delay
    logic        held_up;
    logic        held_down;
    logic        run;
    logic        rep;
    logic [31:0] target;

    always_comb begin
        // Both directions held cancels each other: no repeat.
        held_up   = key_down[KEY_UP] & ~key_down[KEY_DOWN];
        held_down = key_down[KEY_DOWN] & ~key_down[KEY_UP];
        run       = active & (held_up | held_down);
        target    = first_q ? REPEAT_DELAY : REPEAT_PERIOD;
        rep       = run & ~press & (cnt_q == target - 32'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else if (press || !run) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else if (rep) begin
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign step_up   = press_up | (rep & held_up);
    assign step_down = press_down | (rep & held_down);
`else
    // No repeat: clock, reset and timing parameters are intentionally idle.
    logic unused_ok;
    assign unused_ok = ^{clk, rst, active, REPEAT_DELAY[0], REPEAT_PERIOD[0]};

    assign step_up   = press_up;
    assign step_down = press_down;
`endif

endmodule

// File: rtl/menu_ctrl.sv
// menu_ctrl: keyboard-driven level-select menu controller.
// Keeps the highlighted row (map), latches the confirmed row (level) and
// pulses start for one cycle on ENTER. Optional auto-repeat of held UP/DOWN
// keys is enabled by defining MENU_CTRL_AUTOREPEAT_EN.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           menu screen active; low forces IDLE and ignores keys
//   key_down     per-scancode held flags from the keyboard decoder
//   last_change  scancode of the most recent make/break event
//   key_valid    one-cycle strobe qualifying last_change
//   map          highlighted row, 0 = bottom, NUM_ITEMS-1 = top
//   level        last confirmed row
//   start        one-cycle confirm pulse
//   busy         high while browsing
module menu_ctrl
    import menu_pkg::*;
#(
    parameter int unsigned NUM_ITEMS     = MENU_ITEMS,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 12_500_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    output logic [2:0]   map,
    output logic [2:0]   level,
    output logic         start,
    output logic         busy
);

    localparam logic [2:0] MAP_MAX = 3'(NUM_ITEMS - 1);

    menu_state_e state_q;
    logic [2:0]  map_q;
    logic [2:0]  level_q;
    logic        start_q;
    logic        step_up;
    logic        step_down;
    logic        press_enter;
    logic        press_esc;

    assign press_enter = key_valid & key_down[last_change] & (last_change == KEY_ENTER);
    assign press_esc   = key_valid & key_down[last_change] & (last_change == KEY_ESC);

    key_step_gen #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_key_step_gen (
        .clk         (clk),
        .rst         (rst),
        .active      (state_q == BROWSE),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_down    (key_down),
        .step_up     (step_up),
        .step_down   (step_down)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            map_q   <= MAP_MAX;
            level_q <= 3'd0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (!en) begin
                // map_q is deliberately kept so re-entry shows the old highlight.
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= BROWSE;
                    BROWSE: begin
                        if (step_up) begin
                            map_q <= (map_q == MAP_MAX) ? 3'd0 : map_q + 3'd1;
                        end else if (step_down) begin
                            map_q <= (map_q == 3'd0) ? MAP_MAX : map_q - 3'd1;
                        end
                        if (press_enter) begin
                            // level and start land together in the CONFIRM cycle.
                            state_q <= CONFIRM;
                            level_q <= map_q;
                            start_q <= 1'b1;
                        end
                    end
                    CONFIRM: state_q <= LOCKED;
                    LOCKED: begin
                        if (press_esc) begin
                            state_q <= BROWSE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign map   = map_q;
    assign level = level_q;
    assign start = start_q;
    assign busy  = (state_q == BROWSE);

endmodule

// File: tb/tb_menu_ctrl.sv
module tb_menu_ctrl;
    import menu_pkg::*;

    logic         clk;
    logic         rst;
    logic         en;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic [2:0]   map;
    logic [2:0]   level;
    logic         start;
    logic         busy;

    int total = 0;
    int bad   = 0;

    menu_ctrl #(
        .NUM_ITEMS     (5),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .map         (map),
        .level       (level),
        .start       (start),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single strobed event; the flag is released right after the edge.
    task automatic strobe(input logic [8:0] code, input logic down);
        last_change    = code;
        key_down[code] = down;
        key_valid      = 1'b1;
        tick();
        key_valid      = 1'b0;
        key_down[code] = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        key_down    = '0;
        last_change = '0;
        key_valid   = 1'b0;
        tick();
        tick();
        check("rst_map", 32'(map), 32'd4);
        check("rst_level", 32'(level), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        en = 1'b1;
        tick();
        check("browse_busy", 32'(busy), 32'd1);

        strobe(KEY_UP, 1'b1);
        check("up_wrap", 32'(map), 32'd0);
        check("up_no_start", 32'(start), 32'd0);
        strobe(KEY_DOWN, 1'b1);
        check("down_wrap", 32'(map), 32'd4);
        strobe(KEY_DOWN, 1'b1);
        check("down_3", 32'(map), 32'd3);
        strobe(KEY_DOWN, 1'b1);
        check("down_2", 32'(map), 32'd2);
        strobe(KEY_DOWN, 1'b1);
        check("down_1", 32'(map), 32'd1);

        strobe(KEY_ENTER, 1'b1);
        check("confirm_start", 32'(start), 32'd1);
        check("confirm_level", 32'(level), 32'd1);
        check("confirm_busy", 32'(busy), 32'd0);
        tick();
        check("locked_start", 32'(start), 32'd0);
        check("locked_level", 32'(level), 32'd1);
        strobe(KEY_UP, 1'b1);
        check("locked_up_ignored", 32'(map), 32'd1);
        check("locked_busy", 32'(busy), 32'd0);

        strobe(KEY_ESC, 1'b1);
        check("esc_busy", 32'(busy), 32'd1);
        strobe(KEY_UP, 1'b1);
        check("esc_up", 32'(map), 32'd2);
        en = 1'b0;
        tick();
        check("en_low_busy", 32'(busy), 32'd0);
        check("en_low_map_kept", 32'(map), 32'd2);

        en = 1'b1;
        tick();
        check("reenter_busy", 32'(busy), 32'd1);
        strobe(KEY_UP, 1'b0);
        check("break_ignored", 32'(map), 32'd2);
        strobe(9'h01C, 1'b1);
        check("unknown_ignored", 32'(map), 32'd2);
        check("unknown_no_start", 32'(start), 32'd0);

        // en low wins over a key event in the same cycle.
        en = 1'b0;
        strobe(KEY_UP, 1'b1);
        check("en_prio_map", 32'(map), 32'd2);
        check("en_prio_busy", 32'(busy), 32'd0);
        en = 1'b1;
        tick();

        strobe(KEY_UP, 1'b1);
        check("b2b_up", 32'(map), 32'd3);
        strobe(KEY_DOWN, 1'b1);
        check("b2b_down", 32'(map), 32'd2);

        strobe(KEY_ENTER, 1'b1);
        check("confirm2_start", 32'(start), 32'd1);
        check("confirm2_level", 32'(level), 32'd2);
        rst = 1'b1;
        #1;
        check("async_rst_start", 32'(start), 32'd0);
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_map", 32'(map), 32'd4);
        check("async_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd1);

        strobe(KEY_UP, 1'b1);
        check("hold_pre_map", 32'(map), 32'd0);
        // Hold UP: press edge, then 20 more cycles with the flag kept set.
        last_change      = KEY_UP;
        key_down[KEY_UP] = 1'b1;
        key_valid        = 1'b1;
        tick();
        key_valid = 1'b0;
        check("hold_press", 32'(map), 32'd1);
        repeat (20) tick();
`ifdef MENU_CTRL_AUTOREPEAT_EN
        check("hold_repeat", 32'(map), 32'd4);
`else
        check("hold_repeat", 32'(map), 32'd1);
`endif
        key_down[KEY_UP] = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/menu_ctrl.md
# menu_ctrl

Keyboard-driven controller for the level-select menu. It decodes PS/2 key events from the keyboard decoder and keeps the highlighted item. It drives the 3-bit `map` index that the menu renderer uses to pick the dark button. It latches the confirmed choice as `level` and pulses `start` to the top-level game FSM.

## Interface
Parameters:
- NUM_ITEMS, 5, number of menu rows; legal `map` values 0..NUM_ITEMS-1
- REPEAT_DELAY, 50_000_000, cycles a held key waits before auto-repeat starts (only with the macro)
- REPEAT_PERIOD, 12_500_000, cycles between auto-repeat steps (only with the macro)

Ports (single clock `clk`; reset `rst` is asynchronous, active-high):
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en  input  1  menu screen active; low means the block ignores keys
- key_down  input  512  per-scancode held flags from the keyboard decoder
- last_change  input  9  scancode of the most recent make/break event
- key_valid  input  1  one-cycle strobe; `last_change` is valid on this cycle
- map  output  3  highlighted item; 0 is the bottom row and NUM_ITEMS-1 is the top row
- level  output  3  last confirmed item
- start  output  1  one-cycle pulse on confirm
- busy  output  1  high while in the BROWSE state

## Operation
- Press event: `key_valid` is high and `key_down[last_change]` is 1. Break events are ignored.
- Keys (scancodes from the package): UP 9'h075, DOWN 9'h072, ENTER 9'h05A, ESC 9'h076. All other codes are ignored.
- States:
  - IDLE: entered from reset, and from any state whenever `en` is low.
  - BROWSE: entered from IDLE when `en` is high.
  - CONFIRM: entered from BROWSE on ENTER; lasts exactly one cycle.
  - LOCKED: entered from CONFIRM.
- Leaving LOCKED: ESC in LOCKED returns to BROWSE. LOCKED also returns to IDLE when `en` goes low.
- BROWSE moves:
  - UP: `map` = `map`+1. From NUM_ITEMS-1 it wraps to 0.
  - DOWN: `map` = `map`-1. From 0 it wraps to NUM_ITEMS-1.
- CONFIRM: `level` <= `map` and `start`=1.
- Keys have no effect in IDLE or CONFIRM. In LOCKED only ESC has an effect.
- `map` is kept when passing through IDLE, so re-entering the menu shows the previous highlight.
- `en` low has priority over any key event in the same cycle.

## Timing
- Reset values: `map`=NUM_ITEMS-1 (top row), `level`=0, `start`=0, `busy`=0, state IDLE.
- Reset is asynchronous. Asserting it mid-browse or mid-confirm forces all reset values immediately. A pending `start` is dropped.
- Latency from key event to output:
  - `map` updates on the clock edge that samples `key_valid`. It is visible one cycle after the strobe.
  - On ENTER: CONFIRM is the next cycle after the strobe, and `start` is high during that cycle. `level` is valid in the same cycle as `start` and holds afterwards.
- `start` is never high for two consecutive cycles.
- `busy` is high exactly in BROWSE.
- One key event is processed per `key_valid` strobe. Strobes arriving back-to-back are each processed.

## Configuration
- Macro: `MENU_CTRL_AUTOREPEAT_EN`.
- When defined:
  - While in BROWSE with UP or DOWN still held (`key_down` flag set), a counter runs.
  - After REPEAT_DELAY cycles it generates one extra step, then one more step every REPEAT_PERIOD cycles.
  - The counter clears on release, on a new press event, or on leaving BROWSE.
  - If both UP and DOWN are held, no repeat occurs.
- When not defined: exactly one step per press event, with no counter logic.

## Structure
- Shared package `menu_pkg`:
  - scancode constants KEY_UP, KEY_DOWN, KEY_ENTER, KEY_ESC
  - state enum {IDLE, BROWSE, CONFIRM, LOCKED}
  - item-count constant MENU_ITEMS=5
- One sub-module, `key_step_gen`. It turns a press event, plus the optional held-key repeat, into one-cycle `step_up` and `step_down` pulses. The repeat logic lives only there, under the macro.
- Top-level `menu_ctrl` contains only the state machine and the `map`/`level` registers.

## Test plan
- Reset, then `en`=1, then UP strobe → `map` goes 4→0 (wrap). Then DOWN strobe → `map` goes 0→4.
- From `map`=4: DOWN ×3 → `map`=1. ENTER → `start` high for 1 cycle, `level`=1. A later UP strobe leaves `map`=1 (LOCKED).
- In LOCKED: ESC → BROWSE (`busy`=1). UP → `map`=2. Then `en`=0 → IDLE with `map`=2 kept.
- Break event (`key_down[KEY_UP]`=0 with `key_valid`) and an unknown scancode 9'h01C → `map` unchanged, no `start`.
- Assert `rst` on the CONFIRM cycle → `start` drops immediately, `level`=0, `map`=4.
- With the macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=4: hold UP from `map`=0 for 20 cycles after the press → `map` steps at the press, +10, +14, +18, giving `map`=4 (wrap-aware). Without the macro → `map`=1.
